pipelined_adder: RTL
====================

# pipelined_adder

Parametrised, pipelined successor to the single-bit full adder. Adds two WIDTH-bit operands plus carry-in, splitting the carry chain into STAGES register-separated chunks so wide adds close timing. Uses a valid/ready handshake on both sides with global stall backpressure. Intended as the arithmetic building block for the datapath steps that follow the full adder.

## Interface
- WIDTH, default 16: operand and sum width in bits; WIDTH >= 1.
- STAGES, default 4: pipeline depth and number of carry-chain chunks; 1 <= STAGES <= WIDTH; WIDTH % STAGES == 0 is required, otherwise elaboration fails.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands on a, b, carry_in are valid.
- in_ready  output  1  pipeline accepts input this cycle.
- a  input  WIDTH  operand A, unsigned (two's complement when overflow is compiled in).
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- out_valid  output  1  sum and carry_out hold a result.
- out_ready  input  1  downstream consumes the result this cycle.
- sum  output  WIDTH  (a + b + carry_in) mod 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow; present only with PIPELINED_ADDER_OVERFLOW_EN.

## Operation
- Chunk width CW = WIDTH/STAGES. Stage k (0-based) adds bits [k*CW +: CW] of a and b, plus the carry registered by stage k-1 (carry_in for stage 0).
- Each stage register holds: valid bit, finished low sum bits, carry, and the still-unadded upper chunks of a and b. Stage STAGES-1 drives sum, carry_out and out_valid.
- Global advance: adv = !out_valid || out_ready. When adv is 1, every stage shifts forward by one and stage 0 captures the inputs, with valid = in_valid. When adv is 0, every register holds.
- in_ready = adv. The input handshake completes when in_valid && in_ready; the output handshake completes when out_valid && out_ready.
- Bubbles are not collapsed. Invalid stages advance along with valid ones. Data in invalid stages is don't-care, but outputs never change while out_valid=1 and out_ready=0.
- Arithmetic: {carry_out, sum} = a + b + carry_in, computed at WIDTH+1 bits and exact for all inputs.
- No state machine beyond the per-stage valid bits. The block holds at most STAGES results in flight.

## Timing
- Latency is STAGES cycles. An input accepted at edge n appears on the outputs after edge n+STAGES-1 (visible in cycle n+STAGES), provided there is no stall.
- Throughput is one result per cycle while out_ready=1.
- in_ready is combinational from out_valid and out_ready. No other combinational input-to-output path exists.
- Reset: all valid bits clear. Outputs after reset: out_valid=0, in_ready=1, sum=0, carry_out=0, overflow=0. All data registers reset to 0.
- Reset mid-operation discards every in-flight result. No result emerges from before the reset.
- Simultaneous output consumption and input acceptance in the same cycle is legal and sustains full throughput.
- STAGES=1: a single registered adder with latency 1.

## Configuration
- PIPELINED_ADDER_OVERFLOW_EN defined:
  - The overflow port exists.
  - overflow = carry into bit WIDTH-1 XOR carry_out, registered alongside sum.
  - It obeys the same valid and stall rules as sum.
- Not defined: the overflow port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst for 2 cycles while in_valid=1 -> out_valid=0, in_ready=1, sum=0, carry_out=0 throughout reset and for STAGES cycles after.
- Single add, WIDTH=8, STAGES=2: a=8'hFF, b=8'h01, carry_in=0, out_ready=1 -> after 2 cycles out_valid=1, sum=8'h00, carry_out=1. Cross-chunk carry must be correct.
- Streaming, WIDTH=16, STAGES=4: 100 back-to-back random operands with out_ready=1 -> one result per cycle, in order, each matching a+b+carry_in at 17 bits. in_ready stays 1.
- Backpressure: stream with out_ready=0 for 5 cycles mid-stream -> in_ready=0 and outputs frozen during the stall. No result lost or duplicated. Order preserved after release.
- Reset mid-stream: rst asserted with 3 results in flight -> none of them ever appears. The first result after reset corresponds to the first input accepted after reset.
- With PIPELINED_ADDER_OVERFLOW_EN, WIDTH=8: 8'h7F+8'h01 -> sum=8'h80, overflow=1. Then 8'h80+8'hFF -> sum=8'h7F, carry_out=1, overflow=1. Then 8'hFF+8'h01 -> overflow=0, carry_out=1.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder with carry in/out. The carry chain is cut
// into STAGES equal chunks with a register after each chunk. Valid/ready
// handshake on both sides, with one global stall for the whole pipeline.
// Optional feature macro: PIPELINED_ADDER_OVERFLOW_EN adds a registered
// signed-overflow output that follows the same valid and stall rules as sum.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = (STAGES > 0) ? (WIDTH / STAGES) : 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % CW) != 0 || (CW * STAGES) != WIDTH) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // The whole pipeline moves together; only a full, unconsumed output stalls it.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE = k * CW;        // low bits already summed before this stage
        localparam int LEFT = WIDTH - DONE;  // operand bits still to be added on entry

        logic                 vld_d;
        logic                 cin_d;
        logic [LEFT-1:0]      opa;
        logic [LEFT-1:0]      opb;
        logic [DONE+CW-1:0]   sum_d;
        logic [CW:0]          part;

        logic                 vld_q;
        logic                 carry_q;
        logic [DONE+CW-1:0]   sum_q;

        if (k == 0) begin : g_head
            assign vld_d = in_valid;
            assign cin_d = carry_in;
            assign opa   = a;
            assign opb   = b;
            assign sum_d = part[CW-1:0];
        end else begin : g_link
            assign vld_d = g_stage[k-1].vld_q;
            assign cin_d = g_stage[k-1].carry_q;
            assign opa   = g_stage[k-1].g_keep.rem_a;
            assign opb   = g_stage[k-1].g_keep.rem_b;
            assign sum_d = {part[CW-1:0], g_stage[k-1].sum_q};
        end

        // Lowest not-yet-added chunk of each operand plus the incoming carry.
        assign part = {1'b0, opa[CW-1:0]} + {1'b0, opb[CW-1:0]} + {{CW{1'b0}}, cin_d};

        // Stage register: valid bit, finished sum bits and chunk carry-out.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                vld_q   <= vld_d;
                carry_q <= part[CW];
                sum_q   <= sum_d;
            end
        end

        if (LEFT > CW) begin : g_keep
            logic [LEFT-CW-1:0] rem_a;
            logic [LEFT-CW-1:0] rem_b;

            // Carry the still-unadded upper chunks forward to later stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rem_a <= '0;
                    rem_b <= '0;
                end else if (adv) begin
                    rem_a <= opa[LEFT-1:CW];
                    rem_b <= opb[LEFT-1:CW];
                end
            end
        end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_ovf
            logic msb_cin;
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            assign msb_cin = part[CW-1] ^ opa[CW-1] ^ opb[CW-1];

            // Signed overflow registered in step with the final sum chunk.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= msb_cin ^ part[CW];
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign carry_out = g_stage[STAGES-1].carry_q;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    assign overflow  = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
